// File: rtl/jk_ctrl_pkg.sv
// Shared definitions for JK bank controllers: op codes, sequencer states and
// the expected-readback rule.
package jk_ctrl_pkg;

  // Op encoding is the {j,k} pair driven onto the target bit.
  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_RESET  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    CHECK = 2'b10
  } jk_state_t;

  // Value a JK flip-flop should hold after one clock of the given op.
  function automatic logic jk_expect(input logic [1:0] op, input logic q_prev);
    logic res;
    case (op)
      OP_RESET:  res = 1'b0;
      OP_SET:    res = 1'b1;
      OP_TOGGLE: res = ~q_prev;
      default:   res = q_prev;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester at or after ptr wins.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PTRW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PTRW-1:0] ptr,
  output logic [NREQ-1:0] win_oh,
  output logic [PTRW-1:0] win_idx,
  output logic            win_vld
);

  // Scan requesters in priority order ptr, ptr+1, ... wrapping at NREQ.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    win_vld = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      int unsigned cand;
      cand = (32'(ptr) + i) % NREQ;
      if (!win_vld && req[cand]) begin
        win_vld      = 1'b1;
        win_oh[cand] = 1'b1;
        win_idx      = PTRW'(cand);
      end
    end
  end

endmodule

// File: rtl/jk_cmd_arbiter.sv
// Round-robin command sequencer for an external JK flip-flop bank. Grants one
// requester per transaction, drives its j/k pair for one clock, reads the bit
// back and flags mismatches or bad indices on a sticky err.
module jk_cmd_arbiter
  import jk_ctrl_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned NBITS = 8,
  parameter int unsigned IDXW  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*IDXW-1:0] req_idx,
  input  logic [NREQ*2-1:0]    req_op,
  input  logic [NBITS-1:0]     q_in,
  output logic [NBITS-1:0]     j_out,
  output logic [NBITS-1:0]     k_out,
  output logic [NREQ-1:0]      gnt,
  output logic                 busy,
  output logic                 err
);

  localparam int unsigned PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  jk_state_t        state;
  logic [PTRW-1:0]  ptr;
  logic [PTRW-1:0]  win_q;
  logic [NREQ-1:0]  win_oh_q;
  logic [IDXW-1:0]  idx_q;
  logic [1:0]       op_q;
  logic             qprev_q;
  logic             oor_q;

  logic [NREQ-1:0]  win_oh;
  logic [PTRW-1:0]  win_idx;
  logic             win_vld;
  logic [IDXW-1:0]  idx_sel;
  logic [1:0]       op_sel;
  logic             sel_ok;
  logic             q_sel;
  logic [NBITS-1:0] j_sel;
  logic [NBITS-1:0] k_sel;
  logic             q_chk;
  logic [PTRW-1:0]  ptr_nxt;

  rr_arbiter #(
    .NREQ (NREQ),
    .PTRW (PTRW)
  ) u_rr (
    .req     (req),
    .ptr     (ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .win_vld (win_vld)
  );

  // Pick out the winning requester's index and op.
  always_comb begin
    idx_sel = '0;
    op_sel  = OP_HOLD;
    for (int unsigned r = 0; r < NREQ; r++) begin
      if (win_oh[r]) begin
        idx_sel = req_idx[r*IDXW +: IDXW];
        op_sel  = req_op[r*2 +: 2];
      end
    end
  end

  // Decode the selected index: range check, current q and the one-hot j/k drive.
  always_comb begin
    sel_ok = 1'b0;
    q_sel  = 1'b0;
    j_sel  = '0;
    k_sel  = '0;
    for (int unsigned b = 0; b < NBITS; b++) begin
      if (32'(idx_sel) == b) begin
        sel_ok   = 1'b1;
        q_sel    = q_in[b];
        j_sel[b] = op_sel[1];
        k_sel[b] = op_sel[0];
      end
    end
  end

  // Readback of the latched bit; unused when the index was out of range.
  always_comb begin
    q_chk = 1'b0;
    for (int unsigned b = 0; b < NBITS; b++) begin
      if (32'(idx_q) == b) begin
        q_chk = q_in[b];
      end
    end
  end

  // Pointer moves just past the winner so it has lowest priority next time.
  always_comb begin
    ptr_nxt = (32'(win_q) == NREQ - 1) ? '0 : win_q + PTRW'(1);
  end

  assign busy = (state != IDLE);

  // Sequencer: IDLE latches a winner and drives j/k, ISSUE hands over to the
  // bank edge and raises gnt, CHECK compares the readback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= '0;
      win_q    <= '0;
      win_oh_q <= '0;
      idx_q    <= '0;
      op_q     <= OP_HOLD;
      qprev_q  <= 1'b0;
      oor_q    <= 1'b0;
      j_out    <= '0;
      k_out    <= '0;
      gnt      <= '0;
      err      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (win_vld) begin
            win_q    <= win_idx;
            win_oh_q <= win_oh;
            idx_q    <= idx_sel;
            op_q     <= op_sel;
            qprev_q  <= q_sel;
            oor_q    <= !sel_ok;
            j_out    <= j_sel;
            k_out    <= k_sel;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          j_out <= '0;
          k_out <= '0;
          gnt   <= win_oh_q;
          state <= CHECK;
        end
        CHECK: begin
          gnt <= '0;
          ptr <= ptr_nxt;
          if (oor_q || (q_chk != jk_expect(op_q, qprev_q))) begin
            err <= 1'b1;
          end
          state <= IDLE;
        end
        default: begin
          j_out <= '0;
          k_out <= '0;
          gnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_cmd_arbiter.sv
// Bench for jk_cmd_arbiter: behavioural JK bank, queue-based reference model of
// the round-robin command stream, and a monitor that checks each grant.
module tb_jk_cmd_arbiter;

  localparam int NREQ  = 4;
  localparam int NBITS = 6;
  localparam int IDXW  = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ*IDXW-1:0] req_idx;
  logic [NREQ*2-1:0]    req_op;
  logic [NBITS-1:0]     q_in;
  logic [NBITS-1:0]     j_out;
  logic [NBITS-1:0]     k_out;
  logic [NREQ-1:0]      gnt;
  logic                 busy;
  logic                 err;

  jk_cmd_arbiter #(
    .NREQ  (NREQ),
    .NBITS (NBITS),
    .IDXW  (IDXW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .req_idx (req_idx),
    .req_op  (req_op),
    .q_in    (q_in),
    .j_out   (j_out),
    .k_out   (k_out),
    .gnt     (gnt),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  // External JK bank; bits in stuck0 are forced to 0.
  logic [NBITS-1:0] bank   = '0;
  logic [NBITS-1:0] stuck0 = '0;
  assign q_in = bank;

  always @(posedge clk) begin
    logic [NBITS-1:0] nb;
    nb = bank;
    for (int b = 0; b < NBITS; b++) begin
      case ({j_out[b], k_out[b]})
        2'b01:   nb[b] = 1'b0;
        2'b10:   nb[b] = 1'b1;
        2'b11:   nb[b] = ~bank[b];
        default: nb[b] = bank[b];
      endcase
    end
    bank <= nb & ~stuck0;
  end

  typedef struct {
    int               id;
    logic [NBITS-1:0] j;
    logic [NBITS-1:0] k;
    logic [NBITS-1:0] bank;
    logic             err;
    bit               b2b;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int               mdl_ptr  = 0;
  logic             mdl_err  = 1'b0;
  logic [NBITS-1:0] mdl_bank = '0;

  // Per-requester batch description: number of commands, index and op.
  int         b_cnt [NREQ];
  logic [2:0] b_idx [NREQ];
  logic [1:0] b_op  [NREQ];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model the batch as a round-robin queue of commands, then drive it.
  task automatic run_batch();
    int   left [NREQ];
    int   rem  [NREQ];
    int   ncmd;
    int   n;
    bit   first;
    exp_t e;
    ncmd  = 0;
    first = 1'b1;
    for (int r = 0; r < NREQ; r++) begin
      left[r] = b_cnt[r];
      rem[r]  = b_cnt[r];
      ncmd   += b_cnt[r];
    end
    for (int c = 0; c < ncmd; c++) begin
      int   w;
      int   ix;
      logic prev;
      logic want;
      w = -1;
      for (int s = 0; s < NREQ; s++) begin
        if (w < 0 && left[(mdl_ptr + s) % NREQ] > 0) w = (mdl_ptr + s) % NREQ;
      end
      ix  = int'(b_idx[w]);
      e.id = w;
      e.j  = '0;
      e.k  = '0;
      if (ix < NBITS) begin
        e.j[ix] = b_op[w][1];
        e.k[ix] = b_op[w][0];
        prev = mdl_bank[ix];
        case (b_op[w])
          2'b00:   want = prev;
          2'b01:   want = 1'b0;
          2'b10:   want = 1'b1;
          default: want = ~prev;
        endcase
        mdl_bank[ix] = want & ~stuck0[ix];
        if (mdl_bank[ix] != want) mdl_err = 1'b1;
      end else begin
        mdl_err = 1'b1;
      end
      e.bank = mdl_bank;
      e.err  = mdl_err;
      e.b2b  = !first;
      first  = 1'b0;
      exp_q.push_back(e);
      mdl_ptr = (w + 1) % NREQ;
      left[w]--;
    end

    for (int r = 0; r < NREQ; r++) begin
      req_idx[r*IDXW +: IDXW] = b_idx[r];
      req_op[r*2 +: 2]        = b_op[r];
      req[r]                  = (b_cnt[r] > 0);
    end
    n = 0;
    while (req != '0 && n < 3 * ncmd + 10) begin
      @(negedge clk);
      n++;
      for (int r = 0; r < NREQ; r++) begin
        if (gnt[r] && req[r]) begin
          rem[r]--;
          if (rem[r] == 0) req[r] = 1'b0;
        end
      end
    end
    if (req != '0) begin
      check("batch_timeout", 32'(req), 32'd0);
      req = '0;
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_batch();
    for (int r = 0; r < NREQ; r++) begin
      b_cnt[r] = 0;
      b_idx[r] = 3'd0;
      b_op[r]  = 2'b00;
    end
  endtask

  task automatic random_batches(input int count, input int max_idx);
    for (int it = 0; it < count; it++) begin
      logic [NREQ-1:0] m;
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int r = 0; r < NREQ; r++) begin
        b_cnt[r] = m[r] ? $urandom_range(1, 2) : 0;
        b_idx[r] = 3'($urandom_range(0, max_idx));
        b_op[r]  = 2'($urandom_range(0, 3));
      end
      run_batch();
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    @(negedge clk);
    rst     = 1'b1;
    mdl_ptr = 0;
    mdl_err = 1'b0;
    @(negedge clk);
  endtask

  int   cyc      = 0;
  int   last_gnt = 0;
  bit   err_pend = 1'b0;
  logic pend_err;
  logic [NBITS-1:0] prev_j = '0;
  logic [NBITS-1:0] prev_k = '0;

  initial begin
    rst     = 1'b0;
    req     = '0;
    req_idx = '0;
    req_op  = '0;
    fork
      begin : stim
        repeat (3) @(negedge clk);
        check("rst_j", 32'(j_out), 32'd0);
        check("rst_k", 32'(k_out), 32'd0);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Single set on bit 3 from requester 0.
        clear_batch();
        b_cnt[0] = 1; b_idx[0] = 3'd3; b_op[0] = 2'b10;
        run_batch();

        // Requester 1 toggles bit 5 twice back to back.
        clear_batch();
        b_cnt[1] = 2; b_idx[1] = 3'd5; b_op[1] = 2'b11;
        run_batch();

        // All four contend, then 3 and 0 together after the pointer wraps.
        clear_batch();
        for (int r = 0; r < NREQ; r++) begin
          b_cnt[r] = 1; b_idx[r] = 3'(r + 1); b_op[r] = 2'(r);
        end
        run_batch();
        clear_batch();
        b_cnt[3] = 1; b_idx[3] = 3'd2; b_op[3] = 2'b10;
        b_cnt[0] = 1; b_idx[0] = 3'd4; b_op[0] = 2'b11;
        run_batch();

        random_batches(25, NBITS - 1);

        // Reset while the command is in ISSUE: no grant, outputs cleared at once.
        req_idx[3*IDXW +: IDXW] = 3'd1;
        req_op[3*2 +: 2]        = 2'b10;
        req[3]                  = 1'b1;
        @(negedge clk);
        check("issue_busy", 32'(busy), 32'd1);
        check("issue_j", 32'(j_out), 32'h02);
        rst = 1'b0;
        #1;
        check("midrst_j", 32'(j_out), 32'd0);
        check("midrst_k", 32'(k_out), 32'd0);
        check("midrst_gnt", 32'(gnt), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        req = '0;
        @(negedge clk);
        rst     = 1'b1;
        mdl_ptr = 0;
        mdl_err = 1'b0;
        @(negedge clk);
        clear_batch();
        b_cnt[3] = 1; b_idx[3] = 3'd0; b_op[3] = 2'b11;
        run_batch();

        // Out-of-range index: no drive, grant still given, err set.
        clear_batch();
        b_cnt[2] = 1; b_idx[2] = 3'd7; b_op[2] = 2'b10;
        run_batch();
        random_batches(10, 7);

        // Bit 0 stuck at 0: a set on it must raise err, which then sticks.
        pulse_reset();
        stuck0   = 6'b000001;
        mdl_bank = mdl_bank & ~stuck0;
        @(negedge clk);
        clear_batch();
        b_cnt[0] = 1; b_idx[0] = 3'd0; b_op[0] = 2'b10;
        run_batch();
        for (int it = 0; it < 6; it++) begin
          clear_batch();
          b_cnt[it % NREQ] = 1;
          b_idx[it % NREQ] = 3'($urandom_range(1, NBITS - 1));
          b_op[it % NREQ]  = 2'($urandom_range(0, 3));
          run_batch();
        end
        check("err_final", 32'(err), 32'd1);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
      end
      begin : mon
        forever begin
          exp_t e;
          @(negedge clk);
          cyc++;
          if (err_pend) begin
            check("err", 32'(err), 32'(pend_err));
            err_pend = 1'b0;
          end
          if (gnt != '0) begin
            if (exp_q.size() == 0) begin
              check("gnt_unexpected", 32'(gnt), 32'd0);
            end else begin
              e = exp_q.pop_front();
              check("gnt", 32'(gnt), 32'(1) << e.id);
              check("issue_j_drive", 32'(prev_j), 32'(e.j));
              check("issue_k_drive", 32'(prev_k), 32'(e.k));
              check("bank", 32'(bank), 32'(e.bank));
              if (e.b2b) check("gnt_spacing", 32'(cyc - last_gnt), 32'd3);
              last_gnt = cyc;
              err_pend = 1'b1;
              pend_err = e.err;
            end
          end
          prev_j = j_out;
          prev_k = k_out;
        end
      end
    join_any
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
